// File: rtl/thor_pkg.sv
// Shared definitions for the interrupt controller slice.
//
// Contents:
//   XLEN_DEFAULT       default width of handler addresses and config data
//   IRQ_ID_W           width of the source id carried to the CPU
//   CFG_MASK/CFG_VBASE configuration register selectors for cfgAddr
//   irqState_e         controller FSM state encoding
//   handlerOffset()    byte offset of a source's vector-table slot
package thor_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int IRQ_ID_W     = 5;

  localparam logic CFG_MASK  = 1'b0;
  localparam logic CFG_VBASE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irqState_e;

  // Each vector-table slot is one 32-bit word, so the slot offset is id*4.
  function automatic logic [IRQ_ID_W+1:0] handlerOffset(input logic [IRQ_ID_W-1:0] id);
    return {id, 2'b00};
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of a request vector.
//
// Ports:
//   reqVec  input  NUM_SRC  candidate requests (pending & mask)
//   valid   output 1        at least one bit of reqVec is set
//   index   output 5        index of the lowest set bit (0 when none set)
module irq_priority_encoder #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] reqVec,
  output logic               valid,
  output logic [4:0]         index
);

  // Scanning from the top down lets the lowest set bit overwrite the rest,
  // which gives index 0 the highest priority.
  always_comb begin
    index = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        index = 5'(i);
      end
    end
    valid = |reqVec;
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered, fixed-priority, non-nesting interrupt controller.
//
// Ports:
//   clock             input  1        single clock, rising edge
//   resetn            input  1        asynchronous active-low reset
//   irqSrc            input  NUM_SRC  source lines, rising-edge sensitive
//   cfgWe             input  1        configuration write strobe
//   cfgAddr           input  1        0 = enable mask, 1 = vector base
//   cfgWData          input  XLEN     configuration write data
//   interruptRequest  output 1        registered request to the CPU
//   handlerAddr       output XLEN     vectorBase + irqId*4, valid with request
//   interruptTaken    input  1        CPU acceptance pulse
//   irqDone           input  1        CPU end-of-handler pulse
//   irqId             output 5        id of the in-flight/in-service source
module irq_controller
  import thor_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int NUM_SRC = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] irqSrc,
  input  logic               cfgWe,
  input  logic               cfgAddr,
  input  logic [XLEN-1:0]    cfgWData,
  output logic               interruptRequest,
  output logic [XLEN-1:0]    handlerAddr,
  input  logic               interruptTaken,
  input  logic               irqDone,
  output logic [4:0]         irqId
);

  irqState_e          state_q, state_d;
  logic [NUM_SRC-1:0] prevSrc_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [XLEN-1:0]    vectorBase_q, vectorBase_d;
  logic               request_q, request_d;
  logic [XLEN-1:0]    handlerAddr_q, handlerAddr_d;
  logic [4:0]         irqId_q, irqId_d;

  logic [NUM_SRC-1:0] edgeVec;
  logic [NUM_SRC-1:0] clearVec;
  logic               winValid;
  logic [4:0]         winIndex;

  assign edgeVec = irqSrc & ~prevSrc_q;

  // Arbitration always looks at registered mask/pending, so a config write
  // landing on the same edge only affects the following cycle.
  irq_priority_encoder #(
    .NUM_SRC(NUM_SRC)
  ) uEncoder (
    .reqVec(pending_q & mask_q),
    .valid (winValid),
    .index (winIndex)
  );

  // Configuration registers.
  always_comb begin
    mask_d       = mask_q;
    vectorBase_d = vectorBase_q;
    if (cfgWe) begin
      if (cfgAddr == CFG_MASK) begin
        mask_d = cfgWData[NUM_SRC-1:0];
      end else begin
        vectorBase_d = cfgWData;
      end
    end
  end

  // FSM next state plus the registered request outputs. Clearing of the
  // accepted source is expressed as a vector so a same-cycle edge can
  // override it below.
  always_comb begin
    state_d       = state_q;
    request_d     = request_q;
    handlerAddr_d = handlerAddr_q;
    irqId_d       = irqId_q;
    clearVec      = '0;
    unique case (state_q)
      IDLE: begin
        if (winValid) begin
          state_d       = REQUEST;
          request_d     = 1'b1;
          irqId_d       = winIndex;
          handlerAddr_d = vectorBase_q + XLEN'(handlerOffset(winIndex));
        end
      end
      REQUEST: begin
        if (interruptTaken) begin
          state_d   = SERVICE;
          request_d = 1'b0;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (5'(i) == irqId_q) begin
              clearVec[i] = 1'b1;
            end
          end
        end
      end
      SERVICE: begin
        if (irqDone) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        request_d = 1'b0;
      end
    endcase
    // A fresh edge wins over the clear of the same bit.
    pending_d = (pending_q & ~clearVec) | edgeVec;
  end

  // All state registers share the asynchronous reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      prevSrc_q     <= '0;
      pending_q     <= '0;
      mask_q        <= '0;
      vectorBase_q  <= '0;
      request_q     <= 1'b0;
      handlerAddr_q <= '0;
      irqId_q       <= '0;
    end else begin
      state_q       <= state_d;
      prevSrc_q     <= irqSrc;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      vectorBase_q  <= vectorBase_d;
      request_q     <= request_d;
      handlerAddr_q <= handlerAddr_d;
      irqId_q       <= irqId_d;
    end
  end

  assign interruptRequest = request_q;
  assign handlerAddr      = handlerAddr_q;
  assign irqId            = irqId_q;

endmodule
